// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_ARB_STATS_EN to add the per-requester grant counters gnt_cnt0/gnt_cnt1.
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
`ifdef ALU_ARB_STATS_EN
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
`endif
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             r_owner;
    logic             r_lastGrant;
    logic             r_rsp0Valid;
    logic             r_rsp1Valid;
    logic [WIDTH-1:0] r_rspResult;
    logic [WIDTH-1:0] r_aluA;
    logic [WIDTH-1:0] r_aluB;
    logic [OPW-1:0]   r_aluOp;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_rspTaken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // r_lastGrant = 1 means requester 1 won last, so requester 0 wins the next tie.
    always_comb begin
        w_nextState = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_rspTaken  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    if (req0_valid && (!req1_valid || r_lastGrant)) begin
                        w_grant0 = 1'b1;
                    end else if (req1_valid) begin
                        w_grant1 = 1'b1;
                    end
                end
                if (w_grant0 || w_grant1) begin
                    w_nextState = EXEC;
                end
            end
            EXEC: w_nextState = RESP;
            RESP: begin
                w_rspTaken = r_owner ? rsp1_ready : rsp0_ready;
                if (w_rspTaken) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_rsp0Valid <= 1'b0;
            r_rsp1Valid <= 1'b0;
            r_rspResult <= '0;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_aluOp     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0) begin
                        r_aluA      <= req0_a;
                        r_aluB      <= req0_b;
                        r_aluOp     <= req0_op;
                        r_owner     <= 1'b0;
                        r_lastGrant <= 1'b0;
                    end else if (w_grant1) begin
                        r_aluA      <= req1_a;
                        r_aluB      <= req1_b;
                        r_aluOp     <= req1_op;
                        r_owner     <= 1'b1;
                        r_lastGrant <= 1'b1;
                    end
                end
                EXEC: begin
                    r_rspResult <= alu_result;
                    if (r_owner) begin
                        r_rsp1Valid <= 1'b1;
                    end else begin
                        r_rsp0Valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (w_rspTaken) begin
                        r_rsp0Valid <= 1'b0;
                        r_rsp1Valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] r_gntCnt0;
    logic [CNT_W-1:0] r_gntCnt1;

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gntCnt0 <= '0;
            r_gntCnt1 <= '0;
        end else begin
            if (w_grant0) begin
                r_gntCnt0 <= r_gntCnt0 + 1'b1;
            end
            if (w_grant1) begin
                r_gntCnt1 <= r_gntCnt1 + 1'b1;
            end
        end
    end

    assign gnt_cnt0 = r_gntCnt0;
    assign gnt_cnt1 = r_gntCnt1;
`endif

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp0_valid = r_rsp0Valid;
    assign rsp1_valid = r_rsp1Valid;
    assign rsp_result = r_rspResult;
    assign alu_a      = r_aluA;
    assign alu_b      = r_aluB;
    assign alu_op     = r_aluOp;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: bench-side ALU model, scoreboard monitor, vector table
// and directed sequences for contention, backpressure and mid-operation reset.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp_result, alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    int nVectors = 0;
    int nMiscompares = 0;

    typedef struct packed {
        logic       who;
        logic [7:0] res;
    } exp_t;
    exp_t sbQ[$];
    int   grantLog[$];

    typedef struct {
        logic [2:0] op;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[8];

    alu_arbiter #(.WIDTH(8), .OPW(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
`ifdef ALU_ARB_STATS_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] aluModel(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << 1;
            3'd6:    return a >> 1;
            default: return b - a;
        endcase
    endfunction

    assign alu_result = aluModel(alu_a, alu_b, alu_op);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int who, input logic v, input logic [7:0] a,
                                 input logic [7:0] b, input logic [2:0] op);
        if (who == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 20 && sbQ.size() != 0; i++) step();
        checkOutput("drain", sbQ.size(), 0);
    endtask

    task automatic doOp(input int who, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        applyStimulus(who, 1'b1, a, b, op);
        step();
        applyStimulus(who, 1'b0, a, b, op);
        step();
        step();
        step();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sbQ.delete();
        end else begin
            if (req0_ready && req1_ready) checkOutput("dualReady", 1, 0);
            if (req0_valid && req0_ready) begin
                sbQ.push_back({1'b0, aluModel(req0_a, req0_b, req0_op)});
                grantLog.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                sbQ.push_back({1'b1, aluModel(req1_a, req1_b, req1_op)});
                grantLog.push_back(1);
            end
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sbQ.size() == 0) begin
                    checkOutput("sbUnexpectedRsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("sbRsp1Valid", rsp1_valid, e.who);
                    checkOutput("sbRsp0Valid", rsp0_valid, !e.who);
                    checkOutput("sbResult", rsp_result, e.res);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{3'd0, 8'hFF}; vecs[1] = '{3'd1, 8'h55};
        vecs[2] = '{3'd2, 8'h00}; vecs[3] = '{3'd3, 8'hFF};
        vecs[4] = '{3'd4, 8'hFF}; vecs[5] = '{3'd5, 8'h54};
        vecs[6] = '{3'd6, 8'h55}; vecs[7] = '{3'd7, 8'hAB};

        rst = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        applyStimulus(0, 1'b1, 8'h0F, 8'h03, 3'd0);
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 3'd0);
        step();
        step();
        checkOutput("rstReq0Ready", req0_ready, 0);
        checkOutput("rstRsp0Valid", rsp0_valid, 0);
        checkOutput("rstRsp1Valid", rsp1_valid, 0);
        checkOutput("rstRspResult", rsp_result, 0);
        checkOutput("rstAluA", alu_a, 0);
        checkOutput("rstAluOp", alu_op, 0);

        $display("[TB] single requester");
        rst = 1'b0;
        #1;
        checkOutput("singleReady", req0_ready, 1);
        step();
        applyStimulus(0, 1'b0, 8'h0F, 8'h03, 3'd0);
        checkOutput("singleAluA", alu_a, 8'h0F);
        checkOutput("singleAluB", alu_b, 8'h03);
        checkOutput("singleExecReady", req0_ready, 0);
        step();
        checkOutput("singleRspValid", rsp0_valid, 1);
        checkOutput("singleRspResult", rsp_result, 8'h12);
        checkOutput("singleRsp1Quiet", rsp1_valid, 0);
        step();
        checkOutput("singleRspClear", rsp0_valid, 0);
        checkOutput("singleAluHold", alu_a, 8'h0F);

        $display("[TB] contention and fairness");
        rst = 1'b1;
        step();
        rst = 1'b0;
        grantLog.delete();
        applyStimulus(0, 1'b1, 8'hAA, 8'h55, 3'd1);
        applyStimulus(1, 1'b1, 8'h0F, 8'h03, 3'd2);
        #1;
        checkOutput("contReq0Ready", req0_ready, 1);
        checkOutput("contReq1Ready", req1_ready, 0);
        step();
        checkOutput("contAluOp0", alu_op, 3'd1);
        step();
        step();
        checkOutput("contReq1Ready2", req1_ready, 1);
        step();
        checkOutput("contAluOp1", alu_op, 3'd2);
        for (int i = 0; i < 40 && grantLog.size() < 8; i++) step();
        applyStimulus(0, 1'b0, 8'hAA, 8'h55, 3'd1);
        applyStimulus(1, 1'b0, 8'h0F, 8'h03, 3'd2);
        checkOutput("contGrantCount", grantLog.size(), 8);
        for (int i = 0; i < 8 && i < grantLog.size(); i++) begin
            checkOutput($sformatf("contGrant%0d", i), grantLog[i], i % 2);
        end
        waitDrain();

        $display("[TB] backpressure");
        step();
        rsp1_ready = 1'b0;
        applyStimulus(1, 1'b1, 8'h0F, 8'h03, 3'd0);
        #1;
        checkOutput("bpReq1Ready", req1_ready, 1);
        step();
        applyStimulus(1, 1'b0, 8'h0F, 8'h03, 3'd0);
        applyStimulus(0, 1'b1, 8'hAA, 8'h55, 3'd4);
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bpRsp1Valid", rsp1_valid, 1);
            checkOutput("bpRspResult", rsp_result, 8'h12);
            checkOutput("bpReq0Blocked", req0_ready, 0);
            step();
        end
        rsp1_ready = 1'b1;
        #1;
        checkOutput("bpReq0StillBlocked", req0_ready, 0);
        step();
        checkOutput("bpRsp1Clear", rsp1_valid, 0);
        checkOutput("bpReq0Accept", req0_ready, 1);
        step();
        applyStimulus(0, 1'b0, 8'hAA, 8'h55, 3'd4);
        waitDrain();

        $display("[TB] reset mid-operation");
        step();
        applyStimulus(0, 1'b1, 8'h11, 8'h22, 3'd3);
        step();
        applyStimulus(0, 1'b1, 8'hAA, 8'h55, 3'd1);
        applyStimulus(1, 1'b1, 8'h0F, 8'h03, 3'd2);
        rst = 1'b1;
        step();
        checkOutput("midRstRsp0", rsp0_valid, 0);
        checkOutput("midRstRsp1", rsp1_valid, 0);
        checkOutput("midRstAluA", alu_a, 0);
        checkOutput("midRstAluB", alu_b, 0);
        checkOutput("midRstAluOp", alu_op, 0);
        checkOutput("midRstReady0", req0_ready, 0);
        checkOutput("midRstReady1", req1_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("midRstGrant0", req0_ready, 1);
        checkOutput("midRstGrant1", req1_ready, 0);
        step();
        applyStimulus(0, 1'b0, 8'hAA, 8'h55, 3'd1);
        applyStimulus(1, 1'b0, 8'h0F, 8'h03, 3'd2);
        waitDrain();

        $display("[TB] op sweep via requester 1");
        for (int i = 0; i < 8; i++) begin
            step();
            applyStimulus(1, 1'b1, 8'hAA, 8'h55, vecs[i].op);
            #1;
            checkOutput($sformatf("sweepReady%0d", i), req1_ready, 1);
            step();
            applyStimulus(1, 1'b0, 8'hAA, 8'h55, vecs[i].op);
            checkOutput($sformatf("sweepAluOp%0d", i), alu_op, vecs[i].op);
            checkOutput($sformatf("sweepEarly%0d", i), rsp1_valid, 0);
            step();
            checkOutput($sformatf("sweepValid%0d", i), rsp1_valid, 1);
            checkOutput($sformatf("sweepResult%0d", i), rsp_result, vecs[i].exp);
            step();
        end
        waitDrain();

`ifdef ALU_ARB_STATS_EN
        $display("[TB] grant counters");
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) doOp(0, 8'h01, 8'h02, 3'd0);
        for (int i = 0; i < 3; i++) doOp(1, 8'h03, 8'h04, 3'd0);
        checkOutput("gntCnt0", gnt_cnt0, 5);
        checkOutput("gntCnt1", gnt_cnt1, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("gntCnt0Rst", gnt_cnt0, 0);
        checkOutput("gntCnt1Rst", gnt_cnt1, 0);
`else
        doOp(0, 8'h01, 8'h02, 3'd0);
        waitDrain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu_8bit between two independent requesters (req0, req1) using round-robin arbitration. Accepts an operand/opcode transaction from each requester with a valid/ready handshake, drives the shared ALU from registered operands, and captures the ALU result. Returns the result on a per-requester valid/ready response channel. Sits between instruction-issue logic and the shared ALU instance; opcodes pass through unmodified, so no op decoding happens here.

Parameters:
WIDTH, 8, operand/result width (must match the ALU data width)
OPW, 3, opcode width (must match the ALU op width)
CNT_W, 16, grant-counter width (used only when ALU_ARB_STATS_EN is defined)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a transaction
req0_ready  output  1  requester 0 transaction accepted this cycle
req0_a / req0_b  input  WIDTH each  requester 0 operands
req0_op  input  OPW  requester 0 opcode
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as req0, for requester 1
rsp0_valid  output  1  result for requester 0 available
rsp0_ready  input  1  requester 0 consumes the result
rsp1_valid / rsp1_ready  same as rsp0, for requester 1
rsp_result  output  WIDTH  captured result, shared; qualified by rsp0_valid or rsp1_valid
alu_a / alu_b  output  WIDTH each  to the shared ALU
alu_op  output  OPW  to the shared ALU
alu_result  input  WIDTH  from the shared ALU (combinational)
gnt_cnt0 / gnt_cnt1  output  CNT_W each  grant counters (present only with ALU_ARB_STATS_EN)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: FSM=IDLE; req*_ready=0; rsp*_valid=0; rsp_result=0; alu_a=alu_b=0; alu_op=0; last_grant=1, so req0 wins the first contention.
- FSM IDLE: if no req*_valid, stay in IDLE.
  - Otherwise pick the winner: the only valid requester, or if both are valid, the one other than last_grant.
  - req<w>_ready is asserted combinationally in that same cycle; the loser's ready stays 0.
  - On the clock edge: latch a, b and op into alu_a, alu_b, alu_op; record owner=w; set last_grant=w; go to EXEC.
- FSM EXEC (1 cycle): alu_* are stable from registers.
  - On the edge: rsp_result<=alu_result; rsp<owner>_valid<=1; go to RESP.
- FSM RESP: hold rsp<owner>_valid and rsp_result stable until rsp<owner>_ready=1.
  - On that edge: clear valid and go to IDLE.
  - The other requester's rsp valid is never asserted in this state.
- req*_ready is 0 in the EXEC and RESP states; there is no new acceptance while a response is pending.
- Latency: accept at edge N; alu_* valid after N; rsp valid after N+1. With rsp_ready tied high, one op completes every 3 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1,...
- Requester rule: once valid is asserted, a requester holds a/b/op stable until ready. The arbiter samples operands only on the accept edge.
- alu_* keep the last issued operands in IDLE; no glitch back to zero.
- Reset mid-operation: rst in any state returns the FSM to IDLE on that edge.
  - The in-flight result is dropped, rsp*_valid=0, and last_grant=1.
  - No ready is asserted during the reset cycle.
- rsp_ready asserted while the matching valid=0 is ignored.
- Results are passed through at full WIDTH; no carry or flag handling.

Optional Feature:
ALU_ARB_STATS_EN:
- Defined: adds gnt_cnt0 and gnt_cnt1, each incremented on every accept edge for its requester. They wrap modulo 2^CNT_W and clear on rst.
- Undefined: the ports and logic are absent, and the remaining behaviour is identical.

Test Plan:
- Single requester: req0 a=0x0F, b=0x03, op=0 valid at cycle 1 with rsp0_ready=1.
  - Required: req0_ready=1 at cycle 1; alu_a=0x0F, alu_b=0x03 from cycle 2.
  - Required: rsp0_valid=1 at cycle 3 with rsp_result equal to the ALU output; rsp1_valid stays 0.
- Contention after reset: both valid, req0 (0xAA, 0x55, op=1) and req1 (0x0F, 0x03, op=2).
  - Required: req0 granted first, rsp0_valid then rsp1_valid.
  - Required: alu_op sequence 1 then 2; grants alternate over 8 back-to-back ops (0,1,0,1,...).
- Backpressure: hold rsp1_ready=0 for 5 cycles after rsp1_valid rises.
  - Required: rsp_result and rsp1_valid stay stable, and req0_ready stays 0 even with req0_valid=1.
  - Required: after rsp1_ready=1, the next accept is req0 one cycle later.
- Reset mid-op: assert rst in EXEC.
  - Required: next cycle FSM is IDLE, rsp*_valid=0, alu_a=alu_b=alu_op=0.
  - Required: the next contention grants req0 first.
- Full op sweep: for op=0..7 with a=0xAA, b=0x55 via req1.
  - Required: each rsp_result equals the alu_8bit output for that op; latency is exactly 2 cycles after accept.
- With ALU_ARB_STATS_EN: 5 grants to req0 and 3 to req1 give gnt_cnt0=5, gnt_cnt1=3; rst clears both to 0.
